// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving an external full-adder cell
// Operands shift out LSB first; the sum shifts in MSB-side and is published on the last bit.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_x1,
    output logic             fa_x2,
    output logic             fa_x3,
    input  logic             fa_o,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             shift_en;
    logic             last_bit;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST_CNT) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back accept keeps throughput at WIDTH+1 cycles per op
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (shift_en) begin
                a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                sum_sh <= {fa_o, sum_sh[WIDTH-1:1]};
                carry  <= fa_carry;
                cnt    <= cnt + CW'(1);
                if (last_bit) begin
                    sum  <= {fa_o, sum_sh[WIDTH-1:1]};
                    cout <= fa_carry;
                    // carry still holds the carry into the MSB here
                    ovf  <= carry ^ fa_carry;
                end
            end
        end
    end

    always_comb begin
        fa_x1 = 1'b0;
        fa_x2 = 1'b0;
        fa_x3 = 1'b0;
        if (state == SHIFT) begin
            fa_x1 = a_sh[0];
            fa_x2 = b_sh[0];
            fa_x3 = carry;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       fa_x1, fa_x2, fa_x3;
    logic       fa_o, fa_carry;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout, ovf;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .fa_x1    (fa_x1),
        .fa_x2    (fa_x2),
        .fa_x3    (fa_x3),
        .fa_o     (fa_o),
        .fa_carry (fa_carry),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    assign fa_o     = fa_x1 ^ fa_x2 ^ fa_x3;
    assign fa_carry = (fa_x1 & fa_x2) | (fa_x1 & fa_x3) | (fa_x2 & fa_x3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one op from a negedge, returns result at the negedge where done is seen
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcyc, pulses;
        logic [8:0] ref9;
        logic       ref_ovf;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        vecs[0]  = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[9]  = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[10] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);
        check("reset_fa_x", {fa_x1, fa_x2, fa_x3}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcyc);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_busy_cycles", i), bcyc, 8);
            check($sformatf("vec%0d_busy_in_done", i), busy, 0);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), done, 0);
            check($sformatf("vec%0d_fa_idle", i), {fa_x1, fa_x2, fa_x3}, 0);
        end

        // start held during SHIFT with operands changing; one done pulse, original result
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = a + 8'h11; b = b ^ 8'hFF; cin = ~cin;
        end
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                pulses++;
                check("hold_sum", sum, 8'h46);
                check("hold_cout", cout, 0);
                check("hold_ovf", ovf, 0);
            end
            @(negedge clk);
        end
        check("hold_done_pulses", pulses, 1);

        // back-to-back: start in the DONE cycle
        run_op(8'h5A, 8'h33, 1'b0, lat, bcyc);
        check("b2b_first_sum", sum, 8'h8D);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_no_gap", busy, 1);
        check("b2b_done_low", done, 0);
        lat = 0;
        while (!done && lat < 20) begin
            if (lat == 3) check("b2b_sum_stable", sum, 8'h8D);
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 8);
        check("b2b_second_sum", sum, 8'h02);

        // async reset in the middle of SHIFT
        @(negedge clk);
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_fa_x1", fa_x1, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout_ovf", {cout, ovf}, 0);
        check("midrst_fa_x", {fa_x1, fa_x2, fa_x3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h20, 1'b0, lat, bcyc);
        check("postrst_latency", lat, 8);
        check("postrst_sum", sum, 8'h30);

        // strided sweep against an arithmetic reference
        for (int ia = 0; ia < 256; ia += 17) begin
            for (int ib = 3; ib < 256; ib += 13) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(8'(ia), 8'(ib), 1'(ic), lat, bcyc);
                    ref9 = 9'(ia) + 9'(ib) + 9'(ic);
                    ref_ovf = (ia[7] == ib[7]) && (ref9[7] != ia[7]);
                    check($sformatf("sweep_%0h_%0h_%0d", ia, ib, ic),
                          {lat[7:0], cout, ovf, sum}, {8'd8, ref9[8], ref_ovf, ref9[7:0]});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
